life_ctrl: RTL and testbench

LIFE_CTRL -- requirements
Module: life_ctrl

---
 rtl/life_ctrl.sv | 143 ++++++++++++++
 tb/tb_life_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/life_ctrl.sv
// Run controller for an 8x8 Game of Life stage: loads a seed, paces generation
// steps by a programmable divider and halts on extinction, still life, period-2 or limit.
module life_ctrl #(
    parameter int unsigned MAX_GEN = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [63:0] seed,
    input  logic [15:0] div,
    input  logic [63:0] grid_next,
    output logic [63:0] grid,
    output logic        en,
    output logic [15:0] gen,
    output logic        busy,
    output logic        halted,
    output logic [1:0]  cause
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [16:0] MAX_GEN_L = 17'(MAX_GEN);

    state_t      state_q, state_d;
    logic [63:0] grid_q, grid_d;
    logic [63:0] prev_q, prev_d;
    logic        prev_valid_q, prev_valid_d;
    logic [15:0] gen_q, gen_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  cause_q, cause_d;
    logic        en_q, busy_q, halted_q;

    logic        step_due;
    logic        is_extinct, is_still, is_osc2, is_limit, halt_hit;

    // Exact equality only: a counter above a freshly lowered div runs on to wrap.
    assign step_due   = (cnt_q == div);
    assign is_extinct = (grid_next == 64'd0);
    assign is_still   = (grid_next == grid_q);
    assign is_osc2    = prev_valid_q && (grid_next == prev_q);
    assign is_limit   = (({1'b0, gen_q} + 17'd1) == MAX_GEN_L);
    assign halt_hit   = is_extinct || is_still || is_osc2 || is_limit;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_HALT;
                end else if (step_due && halt_hit) begin
                    state_d = S_HALT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        grid_d       = grid_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        gen_d        = gen_q;
        cnt_d        = cnt_q;
        cause_d      = cause_q;
        if (state_q == S_RUN) begin
            if (stop) begin
                cause_d = 2'b00;
            end else if (step_due) begin
                cnt_d        = 16'd0;
                prev_d       = grid_q;
                prev_valid_d = 1'b1;
                grid_d       = grid_next;
                gen_d        = gen_q + 16'd1;
                if (is_extinct)    cause_d = 2'b01;
                else if (is_still) cause_d = 2'b10;
                else if (is_osc2)  cause_d = 2'b11;
                else               cause_d = 2'b00;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end else if (start) begin
            grid_d       = seed;
            gen_d        = 16'd0;
            prev_valid_d = 1'b0;
            cnt_d        = 16'd0;
            cause_d      = 2'b00;
        end
    end

    // Datapath and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            grid_q       <= 64'd0;
            prev_q       <= 64'd0;
            prev_valid_q <= 1'b0;
            gen_q        <= 16'd0;
            cnt_q        <= 16'd0;
            cause_q      <= 2'b00;
            en_q         <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            grid_q       <= grid_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            gen_q        <= gen_d;
            cnt_q        <= cnt_d;
            cause_q      <= cause_d;
            en_q         <= (state_d == S_RUN);
            busy_q       <= (state_d == S_RUN);
            halted_q     <= (state_d == S_HALT);
        end
    end

    assign grid   = grid_q;
    assign en     = en_q;
    assign gen    = gen_q;
    assign busy   = busy_q;
    assign halted = halted_q;
    assign cause  = cause_q;

endmodule

// File: tb/tb_life_ctrl.sv
// Directed bench for life_ctrl with a behavioural 8x8 Life stage (dead border)
// closing the grid -> grid_next loop; one instance at default limit, one at MAX_GEN=2.
module tb_life_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_a = 1'b0, stop_a = 1'b0;
    logic        start_b = 1'b0, stop_b = 1'b0;
    logic [63:0] seed_a = '0, seed_b = '0;
    logic [15:0] div_a = '0, div_b = '0;
    logic [63:0] grid_a, grid_b, gnext_a, gnext_b;
    logic        en_a, en_b, busy_a, busy_b, halted_a, halted_b;
    logic [15:0] gen_a, gen_b;
    logic [1:0]  cause_a, cause_b;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    function automatic logic [63:0] life_step(input logic [63:0] g);
        logic [63:0] n;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int cnt;
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 8 &&
                            (c + dc) >= 0 && (c + dc) < 8) begin
                            if (g[63 - 8 * (r + dr) - (c + dc)]) cnt++;
                        end
                    end
                end
                if (g[63 - 8 * r - c]) n[63 - 8 * r - c] = (cnt == 2 || cnt == 3);
                else                   n[63 - 8 * r - c] = (cnt == 3);
            end
        end
        return n;
    endfunction

    assign gnext_a = life_step(grid_a);
    assign gnext_b = life_step(grid_b);

    life_ctrl u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .stop(stop_a),
        .seed(seed_a), .div(div_a), .grid_next(gnext_a),
        .grid(grid_a), .en(en_a), .gen(gen_a), .busy(busy_a),
        .halted(halted_a), .cause(cause_a)
    );

    life_ctrl #(.MAX_GEN(2)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .stop(stop_b),
        .seed(seed_b), .div(div_b), .grid_next(gnext_b),
        .grid(grid_b), .en(en_b), .gen(gen_b), .busy(busy_b),
        .halted(halted_b), .cause(cause_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
            $display("check %s obs=%h exp=%h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // status word: {en, busy, halted, cause}
    function automatic logic [63:0] st_a();
        return {59'd0, en_a, busy_a, halted_a, cause_a};
    endfunction

    initial begin
        // Reset
        reset = 1'b1; start_a = 1'b1; start_b = 1'b1;
        tick();
        reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
        check("rst_grid", grid_a, 64'd0);
        check("rst_gen", {48'd0, gen_a}, 64'd0);
        check("rst_status", st_a(), 64'd0);

        // Blinker, div=0
        seed_a = 64'h0000_0000_0038_0000; div_a = 16'd0; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("blk_load_grid", grid_a, 64'h0000_0000_0038_0000);
        check("blk_load_status", st_a(), 64'h18);
        tick();
        check("blk_g1_grid", grid_a, 64'h0000_0000_1010_1000);
        check("blk_g1_gen", {48'd0, gen_a}, 64'd1);
        tick();
        check("blk_g2_grid", grid_a, 64'h0000_0000_0038_0000);
        check("blk_g2_gen", {48'd0, gen_a}, 64'd2);
        check("blk_halt_status", st_a(), 64'h07);
        stop_a = 1'b1;
        tick();
        stop_a = 1'b0;
        check("halt_stop_ignored", st_a(), 64'h07);

        // Block, div=3: step lands 4 cycles after start
        seed_a = 64'h0000_0018_1800_0000; div_a = 16'd3; start_a = 1'b1; stop_a = 1'b1;
        tick();
        start_a = 1'b0; stop_a = 1'b0;
        check("block_load_status", st_a(), 64'h18);
        tick(); tick(); tick();
        check("block_pre_step_gen", {48'd0, gen_a}, 64'd0);
        tick();
        check("block_gen", {48'd0, gen_a}, 64'd1);
        check("block_grid", grid_a, 64'h0000_0018_1800_0000);
        check("block_status", st_a(), 64'h06);

        // Lone cell dies
        seed_a = 64'h0000_0000_0800_0000; div_a = 16'd0; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        check("lone_grid", grid_a, 64'd0);
        check("lone_gen", {48'd0, gen_a}, 64'd1);
        check("lone_status", st_a(), 64'h05);

        // Generation limit on the MAX_GEN=2 instance
        seed_b = 64'h0000_0000_2010_7000; div_b = 16'd0; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        tick();
        check("lim_g1_busy", {63'd0, busy_b}, 64'd1);
        tick();
        check("lim_gen", {48'd0, gen_b}, 64'd2);
        check("lim_status", {59'd0, en_b, busy_b, halted_b, cause_b}, 64'h04);

        // Stop in the exact step cycle, div=2
        seed_a = 64'h0000_0000_0038_0000; div_a = 16'd2; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick(); tick(); tick();
        check("stop_g1_gen", {48'd0, gen_a}, 64'd1);
        tick(); tick();
        stop_a = 1'b1;
        tick();
        stop_a = 1'b0;
        check("stop_gen", {48'd0, gen_a}, 64'd1);
        check("stop_grid", grid_a, 64'h0000_0000_1010_1000);
        check("stop_status", st_a(), 64'h04);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("restart_grid", grid_a, 64'h0000_0000_0038_0000);
        check("restart_gen", {48'd0, gen_a}, 64'd0);

        // Start in RUN ignored, then reset mid-interval (div=5, counter=3)
        div_a = 16'd5;
        reset = 1'b1;
        tick();
        reset = 1'b0; start_a = 1'b1;
        tick();
        tick(); tick();
        start_a = 1'b0;
        tick(); tick(); tick();
        check("run_start_ign_gen0", {48'd0, gen_a}, 64'd0);
        tick();
        check("run_start_ign_gen1", {48'd0, gen_a}, 64'd1);
        tick(); tick(); tick();
        reset = 1'b1; start_a = 1'b1; stop_a = 1'b1;
        tick();
        reset = 1'b0; start_a = 1'b0; stop_a = 1'b0;
        check("midrun_rst_grid", grid_a, 64'd0);
        check("midrun_rst_gen", {48'd0, gen_a}, 64'd0);
        check("midrun_rst_status", st_a(), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
